// File: rtl/battle_seq_multi_if.sv
// ============================================================================
// battle_seq_multi_if : key/attack inputs and status outputs of the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface battle_seq_multi_if #(
   parameter int N_MON = 3,
   parameter int HP_W  = 8
);
   localparam int TGT_W = (N_MON > 1) ? $clog2(N_MON) : 1;

   logic [3:0]            keyboard;
   logic                  atk_pass;
   logic [HP_W-1:0]       dmg_mon;
   logic                  is_death;
   logic [7:0]            state;
   logic [15:0]           player_instruction;
   logic                  is_move;
   logic [TGT_W-1:0]      target;
   logic [N_MON*HP_W-1:0] mon_hp;
   logic                  win;
   logic                  lose;

   modport slave (
      input  keyboard, atk_pass, dmg_mon, is_death,
      output state, player_instruction, is_move, target, mon_hp, win, lose
   );

   modport master (
      output keyboard, atk_pass, dmg_mon, is_death,
      input  state, player_instruction, is_move, target, mon_hp, win, lose
   );
endinterface

`default_nettype wire

// File: rtl/battle_seq_multi.sv
// ============================================================================
// battle_seq_multi : multi-monster battle turn sequencer (target, attack, dodge)
// Revision: 1.0
// ============================================================================
`default_nettype none

module battle_seq_multi #(
   parameter int N_MON       = 3,
   parameter int HP_W        = 8,
   parameter int MON_HP_INIT = 100,
   parameter int ATK_WINDOW  = 200,
   parameter int DODGE_CYC   = 1000
) (
   input  wire logic              clk,
   input  wire logic              reset,
   battle_seq_multi_if.slave      bus
);

   localparam int TGT_W   = (N_MON > 1) ? $clog2(N_MON) : 1;
   localparam int TMR_MAX = (ATK_WINDOW > DODGE_CYC) ? ATK_WINDOW : DODGE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] ATK_LAST   = TMR_W'(ATK_WINDOW - 1);
   localparam logic [TMR_W-1:0] DODGE_LAST = TMR_W'(DODGE_CYC - 1);

   typedef enum logic [7:0] {
      S_MENU     = 8'h00,
      S_SELECT   = 8'h01,
      S_ATTACK   = 8'h02,
      S_MON_TURN = 8'h03,
      S_WIN      = 8'h04,
      S_LOSE     = 8'h05
   } state_t;

   state_t             state_q, state_n;
   logic [TGT_W-1:0]   target_q, target_n;
   logic [HP_W-1:0]    hp_q [N_MON];
   logic [HP_W-1:0]    hp_n [N_MON];
   logic [HP_W-1:0]    hp_if_hit [N_MON];
   logic [TMR_W-1:0]   timer_q, timer_n;
   logic [15:0]        instr_q, instr_n;
   logic               is_move_q, is_move_n;
   logic               win_q, win_n;
   logic               lose_q, lose_n;

   logic [3:0]         key_prev, key_edge;
   logic               k_confirm, k_cancel, k_left, k_right;
   logic [(1<<TGT_W)-1:0] alive;
   logic [TGT_W-1:0]   next_alive, prev_alive, lowest_alive;
   logic [HP_W-1:0]    tgt_hp, tgt_hp_hit;
   logic               all_dead_after_hit;

   function automatic logic [TGT_W-1:0] wrap_idx(input int base, input int off);
      return TGT_W'((base + off) % N_MON);
   endfunction

   function automatic logic [15:0] instr_code(input state_t s);
      case (s)
         S_MENU:     return 16'h0001;
         S_SELECT:   return 16'h0002;
         S_ATTACK:   return 16'h0003;
         S_MON_TURN: return 16'h0004;
         S_WIN:      return 16'h00F0;
         S_LOSE:     return 16'h00FF;
         default:    return 16'h0001;
      endcase
   endfunction

   // Edges are registered so that a press acts in the cycle after it is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_prev <= 4'b0;
         key_edge <= 4'b0;
      end else begin
         key_prev <= bus.keyboard;
         key_edge <= bus.keyboard & ~key_prev;
      end
   end

   assign k_confirm = key_edge[0];
   assign k_cancel  = key_edge[1] & ~key_edge[0];
   assign k_left    = key_edge[2] & ~(|key_edge[1:0]);
   assign k_right   = key_edge[3] & ~(|key_edge[2:0]);

   // Neighbour search: descending loops leave the nearest living index in place.
   always_comb begin
      alive        = '0;
      next_alive   = target_q;
      prev_alive   = target_q;
      lowest_alive = '0;
      for (int i = 0; i < N_MON; i++) begin
         alive[i] = (hp_q[i] != '0);
      end
      for (int k = N_MON - 1; k >= 1; k--) begin
         if (alive[wrap_idx(int'(target_q), k)])         next_alive = wrap_idx(int'(target_q), k);
         if (alive[wrap_idx(int'(target_q), N_MON - k)]) prev_alive = wrap_idx(int'(target_q), N_MON - k);
      end
      for (int i = N_MON - 1; i >= 0; i--) begin
         if (alive[i]) lowest_alive = TGT_W'(i);
      end
   end

   assign tgt_hp     = hp_q[target_q];
   assign tgt_hp_hit = (tgt_hp > bus.dmg_mon) ? (tgt_hp - bus.dmg_mon) : '0;

   always_comb begin
      all_dead_after_hit = 1'b1;
      for (int i = 0; i < N_MON; i++) begin
         hp_if_hit[i] = (TGT_W'(i) == target_q) ? tgt_hp_hit : hp_q[i];
         if (hp_if_hit[i] != '0) all_dead_after_hit = 1'b0;
      end
   end

   always_comb begin
      state_n  = state_q;
      target_n = target_q;
      hp_n     = hp_q;
      timer_n  = timer_q;
      case (state_q)
         S_MENU: begin
            if (k_confirm) begin
               state_n = S_SELECT;
               if (!alive[target_q]) target_n = lowest_alive;
            end
         end
         S_SELECT: begin
            if (k_confirm) begin
               state_n = S_ATTACK;
               timer_n = '0;
            end else if (k_cancel) begin
               state_n = S_MENU;
            end else if (k_left) begin
               target_n = prev_alive;
            end else if (k_right) begin
               target_n = next_alive;
            end
         end
         S_ATTACK: begin
            if (k_confirm) begin
               timer_n = '0;
               if (bus.atk_pass) begin
                  hp_n    = hp_if_hit;
                  state_n = all_dead_after_hit ? S_WIN : S_MON_TURN;
               end else begin
                  state_n = S_MON_TURN;
               end
            end else if (timer_q == ATK_LAST) begin
               timer_n = '0;
               state_n = S_MON_TURN;
            end else begin
               timer_n = timer_q + TMR_W'(1);
            end
         end
         S_MON_TURN: begin
            if (timer_q == DODGE_LAST) begin
               timer_n = '0;
               state_n = S_MENU;
            end else begin
               timer_n = timer_q + TMR_W'(1);
            end
         end
         S_WIN, S_LOSE: ;
         default: state_n = S_MENU;
      endcase

      // Player death overrides whatever the active phase decided this cycle.
      if (bus.is_death && (state_q != S_WIN) && (state_q != S_LOSE)) begin
         state_n  = S_LOSE;
         target_n = target_q;
         hp_n     = hp_q;
      end
   end

   always_comb begin
      instr_n   = instr_q;
      is_move_n = (state_n == S_MON_TURN);
      win_n     = win_q  | (state_n == S_WIN);
      lose_n    = lose_q | (state_n == S_LOSE);
      if (state_n != state_q) instr_n = instr_code(state_n);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_MENU;
         target_q  <= '0;
         timer_q   <= '0;
         instr_q   <= 16'h0001;
         is_move_q <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         for (int i = 0; i < N_MON; i++) hp_q[i] <= HP_W'(MON_HP_INIT);
      end else begin
         state_q   <= state_n;
         target_q  <= target_n;
         timer_q   <= timer_n;
         instr_q   <= instr_n;
         is_move_q <= is_move_n;
         win_q     <= win_n;
         lose_q    <= lose_n;
         hp_q      <= hp_n;
      end
   end

   assign bus.state              = state_q;
   assign bus.target             = target_q;
   assign bus.player_instruction = instr_q;
   assign bus.is_move            = is_move_q;
   assign bus.win                = win_q;
   assign bus.lose               = lose_q;

   for (genvar g = 0; g < N_MON; g++) begin : g_hp
      assign bus.mon_hp[g*HP_W +: HP_W] = hp_q[g];
   end

endmodule

`default_nettype wire
